// File: rtl/player_race_judge.sv
// Player-side hop judge: synchronizes the raw keys and judges each new press against the current box.
// A correct hop advances the course and counts down the BCD remaining-box display. A wrong key starts a penalty lockout.
`timescale 1ns/1ps
module player_race_judge #(
  parameter int unsigned PENALTY_CYCLES = 25_000_000,
  parameter int unsigned PEN_W          = 25
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] course,
  input  logic        key_left,
  input  logic        key_right,
  output logic        box_now,
  output logic        advance,
  output logic        miss,
  output logic        penalty,
  output logic [3:0]  remaining_ones,
  output logic [3:0]  remaining_tens,
  output logic        ended
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PENALTY,
    S_DONE
  } state_t;

  localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(PENALTY_CYCLES - 1);

  // Bit 0 is the left key, bit 1 the right key.
  logic [1:0] w_keys;
  logic [1:0] w_press;

  assign w_keys = {key_right, key_left};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic r_sync1;
      logic r_sync2;
      logic r_prev;

      always_ff @(posedge clock) begin
        if (!resetn) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_prev  <= 1'b0;
        end else begin
          r_sync1 <= w_keys[gi];
          r_sync2 <= r_sync1;
          r_prev  <= r_sync2;
        end
      end

      assign w_press[gi] = r_sync2 & ~r_prev;
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_course;
  logic [31:0]      w_course_next;
  logic [3:0]       r_ones;
  logic [3:0]       w_ones_next;
  logic [3:0]       r_tens;
  logic [3:0]       w_tens_next;
  logic [PEN_W-1:0] r_pen_cnt;
  logic [PEN_W-1:0] w_pen_cnt_next;
  logic             r_advance;
  logic             w_advance_next;
  logic             r_miss;
  logic             w_miss_next;
  logic             r_penalty;
  logic             r_ended;
  logic             w_press_ok;
  logic             w_last_box;

  // Only a single new edge on the side of the current box is a valid hop.
  assign w_press_ok = ((w_press == 2'b10) &&  r_course[0]) ||
                      ((w_press == 2'b01) && !r_course[0]);
  assign w_last_box = (r_tens == 4'd0) && (r_ones == 4'd1);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_course  <= course;
      r_ones    <= 4'd2;
      r_tens    <= 4'd3;
      r_pen_cnt <= '0;
      r_advance <= 1'b0;
      r_miss    <= 1'b0;
      r_penalty <= 1'b0;
      r_ended   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_course  <= w_course_next;
      r_ones    <= w_ones_next;
      r_tens    <= w_tens_next;
      r_pen_cnt <= w_pen_cnt_next;
      r_advance <= w_advance_next;
      r_miss    <= w_miss_next;
      r_penalty <= (w_state_next == S_PENALTY);
      r_ended   <= (w_state_next == S_DONE);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_course_next  = r_course;
    w_ones_next    = r_ones;
    w_tens_next    = r_tens;
    w_pen_cnt_next = r_pen_cnt;
    w_advance_next = 1'b0;
    w_miss_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next = S_RUN;
        end
      end

      S_RUN: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else if (w_press != 2'b00) begin
          if (w_press_ok) begin
            w_advance_next = 1'b1;
            w_course_next  = {1'b0, r_course[31:1]};
            if (r_ones != 4'd0) begin
              w_ones_next = r_ones - 4'd1;
            end else if (r_tens != 4'd0) begin
              w_ones_next = 4'd9;
              w_tens_next = r_tens - 4'd1;
            end
            if (w_last_box) begin
              w_state_next = S_DONE;
            end
          end else begin
            w_miss_next    = 1'b1;
            w_pen_cnt_next = PEN_LOAD;
            w_state_next   = S_PENALTY;
          end
        end
      end

      S_PENALTY: begin
        // The lockout clock only runs while the game is running.
        if (enable) begin
          if (r_pen_cnt == '0) begin
            w_state_next = S_RUN;
          end else begin
            w_pen_cnt_next = r_pen_cnt - 1'b1;
          end
        end
      end

      S_DONE: begin
        w_state_next = S_DONE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign box_now        = r_course[0];
  assign advance        = r_advance;
  assign miss           = r_miss;
  assign penalty        = r_penalty;
  assign remaining_ones = r_ones;
  assign remaining_tens = r_tens;
  assign ended          = r_ended;

endmodule
